// File: rtl/fetch_queue.sv
// fetch_queue: instruction buffer between fetch and decode.
//
// Accepts one 16-byte-aligned block of four instructions per cycle, drops the
// leading slots flagged by the fetch aligner, compacts the survivors (with
// their PCs) into a circular queue, and presents up to four oldest entries to
// decode in program order. Decode consumes 0..4 entries per cycle.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   flushD              redirect flush; empties the queue
//   fvalidF, pcF        fetch block valid, aligned block PC
//   alignF/F2/F3        slot 0/1/2 skipped
//   instrF              four 32-bit slots, slot i at [32i+31:32i]
//   freadyF             queue has room for a full block (>= 4 free entries)
//   deqD                number of lanes decode consumes (clamped to count)
//   instrD0..3, pcD0..3 lane i = i-th oldest entry, zero when lane invalid
//   validD              thermometer lane-valid mask
//   countD              current occupancy
module fetch_queue #(
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flushD,
    input  logic                       fvalidF,
    input  logic [31:0]                pcF,
    input  logic                       alignF,
    input  logic                       alignF2,
    input  logic                       alignF3,
    input  logic [127:0]               instrF,
    output logic                       freadyF,
    input  logic [2:0]                 deqD,
    output logic [31:0]                instrD0,
    output logic [31:0]                instrD1,
    output logic [31:0]                instrD2,
    output logic [31:0]                instrD3,
    output logic [31:0]                pcD0,
    output logic [31:0]                pcD1,
    output logic [31:0]                pcD2,
    output logic [31:0]                pcD3,
    output logic [3:0]                 validD,
    output logic [$clog2(DEPTH):0]     countD
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [31:0]   r_instr [DEPTH];
    logic [31:0]   r_pc    [DEPTH];
    logic [AW-1:0] r_head;
    logic [AW-1:0] r_tail;
    logic [CW-1:0] r_count;

    logic [3:0]    w_keep;
    logic [2:0]    w_off [4];
    logic [2:0]    w_kept;
    logic [AW-1:0] w_waddr [4];
    logic          w_accept;
    logic [CW-1:0] w_nenq;
    logic [CW-1:0] w_ndeq;
    logic [CW-1:0] w_deq_ext;
    logic [31:0]   w_lane_instr [4];
    logic [31:0]   w_lane_pc    [4];

    // Slot 3 always survives; earlier slots survive unless the aligner skips them.
    assign w_keep   = {1'b1, ~alignF3, ~alignF2, ~alignF};
    // Readiness uses the registered count only, so a same-cycle dequeue never
    // opens room early and the queue cannot overfill.
    assign freadyF  = (r_count <= CW'(DEPTH - 4));
    assign w_accept = fvalidF && freadyF && !flushD;

    // Compaction offsets: each kept slot lands after all earlier kept slots.
    always_comb begin
        logic [2:0] acc;
        acc = 3'd0;
        for (int s = 0; s < 4; s++) begin
            w_off[s]   = acc;
            w_waddr[s] = r_tail + AW'(acc);
            acc        = acc + {2'b00, w_keep[s]};
        end
        w_kept = acc;
    end

    // Enqueue/dequeue amounts; dequeue requests beyond occupancy are clamped.
    always_comb begin
        w_deq_ext = CW'(deqD);
        if (w_accept) begin
            w_nenq = CW'(w_kept);
        end else begin
            w_nenq = {CW{1'b0}};
        end
        if (w_deq_ext > r_count) begin
            w_ndeq = r_count;
        end else begin
            w_ndeq = w_deq_ext;
        end
    end

    // Pointer and occupancy state; reset takes priority over flush.
    always_ff @(posedge clk) begin
        if (reset || flushD) begin
            r_head  <= {AW{1'b0}};
            r_tail  <= {AW{1'b0}};
            r_count <= {CW{1'b0}};
        end else begin
            r_head  <= r_head + w_ndeq[AW-1:0];
            r_tail  <= r_tail + w_nenq[AW-1:0];
            r_count <= r_count + w_nenq - w_ndeq;
        end
    end

    // Entry storage; not cleared by reset, only written by accepted blocks.
    always_ff @(posedge clk) begin
        for (int s = 0; s < 4; s++) begin
            if (!reset && w_accept && w_keep[s]) begin
                r_instr[w_waddr[s]] <= instrF[32*s +: 32];
                r_pc[w_waddr[s]]    <= pcF + (32'(s) << 2);
            end
        end
    end

    // Decode lanes read head+i across the wrap; invalid lanes show nop / PC 0.
    always_comb begin
        logic [AW-1:0] idx;
        for (int i = 0; i < 4; i++) begin
            idx = r_head + AW'(i);
            if (r_count > CW'(i)) begin
                validD[i]       = 1'b1;
                w_lane_instr[i] = r_instr[idx];
                w_lane_pc[i]    = r_pc[idx];
            end else begin
                validD[i]       = 1'b0;
                w_lane_instr[i] = 32'd0;
                w_lane_pc[i]    = 32'd0;
            end
        end
    end

    assign instrD0 = w_lane_instr[0];
    assign instrD1 = w_lane_instr[1];
    assign instrD2 = w_lane_instr[2];
    assign instrD3 = w_lane_instr[3];
    assign pcD0    = w_lane_pc[0];
    assign pcD1    = w_lane_pc[1];
    assign pcD2    = w_lane_pc[2];
    assign pcD3    = w_lane_pc[3];
    assign countD  = r_count;

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction buffer between the fetch stage and decode in the four-issue pipeline. Each cycle it accepts one 16-byte-aligned fetch block of four instructions, plus the three slot-skip flags produced by the fetch address aligner. It drops the skipped leading slots, compacts the surviving instructions with their PCs into a circular queue, and presents up to four oldest instructions in program order to decode. Decode consumes a variable count per cycle. The queue absorbs the mismatch between fetch width after alignment and decode consumption, and is emptied on redirect.

## Interface
Parameters:
- DEPTH, 8, queue entries; power of two, ≥ 8.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- flushD  in  1  redirect/mispredict flush; empties queue.
- fvalidF  in  1  fetch block on instrF/pcF is valid.
- pcF  in  32  aligned block PC; bits [3:0] are 0.
- alignF  in  1  slot 0 skipped.
- alignF2  in  1  slot 1 skipped.
- alignF3  in  1  slot 2 skipped; slot 3 is never skipped.
- instrF  in  128  slot i at [32i+31:32i].
- freadyF  out  1  queue can accept a full block (free entries ≥ 4).
- deqD  in  3  number of instructions decode consumes this cycle, 0–4.
- instrD0..instrD3  out  32 each  lane i = i-th oldest entry.
- pcD0..pcD3  out  32 each  PC of lane i.
- validD  out  4  bit i set when lane i holds an entry; thermometer pattern.
- countD  out  log2(DEPTH)+1  current occupancy.

## Operation
- State: head pointer, tail pointer (log2(DEPTH) bits, wrap modulo DEPTH), count register, DEPTH entries of {instr, pc}.
- Slot keep mask: keep[0]=!alignF, keep[1]=!alignF2, keep[2]=!alignF3, keep[3]=1.
- nenq is the popcount of keep (1–4); it is 0 unless the accept condition holds.
- Accept condition: fvalidF && freadyF && !flushD.
- Enqueue: kept slots are written in ascending slot order to tail, tail+1, … (mod DEPTH).
  - Entry pc = pcF + 4·slot, in 32-bit wrap-around arithmetic.
  - tail += nenq.
- Non-thermometer flag patterns (e.g. only alignF2 set) are still compacted by the mask; order is preserved.
- Dequeue: ndeq = min(deqD, count); head += ndeq. Values of deqD > count, or 5–7, are clamped to count; this is not an error.
- Count update: count_next = count + nenq − ndeq. It never exceeds DEPTH, because freadyF is computed from the registered count before the same-cycle dequeue (conservative).
- Outputs, combinational from registered state:
  - validD[i] = (count > i).
  - For valid lanes, instrDi/pcDi = entry at head+i.
  - For invalid lanes, instrDi = 0 (MIPS nop) and pcDi = 0.
- freadyF = (DEPTH − count ≥ 4).
- Flush: flushD high discards any enqueue and dequeue in that cycle; head = tail = count = 0 next cycle.
- Reset: same effect as flush. Entry storage is not cleared.
- Simultaneous reset and flush is handled as reset.

## Timing
- Enqueue-to-visible latency is 1 cycle; there is no bypass from instrF to the decode lanes.
- Dequeue takes effect at the next edge. Lanes shift by ndeq in the following cycle.
- freadyF changes one cycle after the count change that causes it.
- After the first rising edge with reset high, and while reset stays high:
  - countD=0, validD=4'b0000, freadyF=1.
  - all instrDi=0, all pcDi=0.
- Full queue (count ≥ DEPTH−3): freadyF=0, and an fvalidF block is ignored. Fetch must hold or replay the block; the queue does not latch it.
- Empty queue with deqD≠0: no state change.
- Pointer wrap at DEPTH−1→0 is seamless; lanes read across the wrap boundary.

## Test plan
- Reset held 2 cycles, then released: countD=0, validD=0000, freadyF=1, all instrD/pcD=0.
- pcF=0x00400000, no flags, instrF slots 0x11,0x22,0x33,0x44, deqD=0:
  - next cycle validD=1111, countD=4.
  - pcD0..3=0x00400000/04/08/0C; instrD0..3=0x11..0x44.
- Empty queue, pcF=0x00400010 with alignF=alignF2=1:
  - next cycle countD=2, validD=0011.
  - instrD0=slot 2, pcD0=0x00400018; instrD1=slot 3, pcD1=0x0040001C.
- DEPTH=8, two full blocks enqueued: freadyF=0.
  - A third block is offered and ignored; countD stays 8.
  - deqD=4: countD=4 and freadyF=1 next cycle, with lanes holding the second block.
- Wrap and ordering: 30 cycles of random valid flag patterns and random deqD 0–7. A scoreboard checks:
  - in-order lane contents and PCs;
  - countD = enq − clamped deq;
  - correct lane data across the pointer wrap.
- Flush while count=6, with simultaneous accepted fvalidF and deqD=3: next cycle countD=0, validD=0000, freadyF=1. A new block enqueued afterward appears in lane 0.
